// File: rtl/fp_div_pkg.sv
// Shared types, constants and FP32 operand classifiers for the sequential divider.
package fp_div_pkg;

  localparam int unsigned FP_MAN_W = 23;
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_QBITS = 26;
  localparam int          FP_BIAS  = 127;

  localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;
  localparam logic [30:0] FP_MAXFIN = 31'h7F7F_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  function automatic logic is_zero(input logic [31:0] f);
    return (f[30:23] == '0) && (f[22:0] == '0);
  endfunction

  function automatic logic is_sub(input logic [31:0] f);
    return (f[30:23] == '0) && (f[22:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == '1) && (f[22:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == '1) && (f[22:0] != '0);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise / round / pack stage for the FP32 quotient.
module fp_round_pack
  import fp_div_pkg::*;
#(
  parameter int unsigned MAN_W = 23,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned QBITS = 26
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  e_z,
  input  logic [QBITS-1:0]         quo,
  input  logic                     sticky,
  input  logic [2:0]               r_mode,
  output logic [EXP_W+MAN_W:0]     fp_z,
  output logic                     ovrf,
  output logic                     udrf
);

  localparam int unsigned EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;
  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);

  logic                  msb;
  logic [MAN_W-1:0]      frac;
  logic                  guard;
  logic                  rest;
  logic                  inc;
  logic [MAN_W:0]        frac_sum;
  logic signed [EW2-1:0] e_n;
  logic signed [EW2-1:0] e_r;

  // With MSB clear the round bit is not generated; folding it into sticky is
  // exact because every mode only needs guard and (round | sticky).
  assign msb   = quo[QBITS-1];
  assign frac  = msb ? quo[QBITS-2 -: MAN_W] : quo[QBITS-3 -: MAN_W];
  assign guard = msb ? quo[QBITS-MAN_W-2] : quo[QBITS-MAN_W-3];
  assign rest  = msb ? (quo[QBITS-MAN_W-3] | sticky) : sticky;
  assign e_n   = msb ? e_z : e_z - E_ONE;

  always_comb begin
    inc = 1'b0;
    case (r_mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | rest);
      RM_RUP:  inc = ~sign & (guard | rest);
      RM_RMM:  inc = guard;
      default: inc = guard & (rest | frac[0]);
    endcase
  end

  assign frac_sum = {1'b0, frac} + (MAN_W+1)'(inc);
  assign e_r      = frac_sum[MAN_W] ? e_n + E_ONE : e_n;

  always_comb begin
    ovrf = 1'b0;
    udrf = 1'b0;
    fp_z = {sign, e_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    if (e_r >= E_MAX) begin
      ovrf = 1'b1;
      if ((r_mode == RM_RTZ) || (r_mode == RM_RDN && !sign) || (r_mode == RM_RUP && sign))
        fp_z = {sign, FP_MAXFIN};
      else
        fp_z = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_r <= E_ZERO) begin
      udrf = 1'b1;
      fp_z = {sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential FP32 restoring divider (1 quotient bit/cycle), FTZ in and out.
// Optional macro FP_DIV_EARLY_TERM_EN: leave DIVIDE once the remainder is zero.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned MAN_W = 23,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned QBITS = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] fp_X,
  input  logic [EXP_W+MAN_W:0] fp_Y,
  input  logic [2:0]           r_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] fp_Z,
  output logic                 ovrf,
  output logic                 udrf,
  output logic                 divz,
  output logic                 nv
);

  localparam int unsigned EW2 = EXP_W + 2;
  localparam int unsigned SW  = MAN_W + 1;
  localparam int unsigned CW  = $clog2(QBITS);
  localparam logic signed [EW2-1:0] BIAS_E = EW2'(FP_BIAS);

  state_e                state;
  logic [SW-1:0]         my;
  logic [SW:0]           rem;
  logic [QBITS-1:0]      quo;
  logic [CW-1:0]         idx;
  logic signed [EW2-1:0] e_z;
  logic                  sign;
  logic [2:0]            rm;

  logic [SW+1:0]         diff;
  logic                  q_bit;
  logic [SW:0]           rem_nx;
  logic                  s_in;
  logic                  x_zero, y_zero, x_inf, y_inf, any_nan;
  logic [EXP_W+MAN_W:0]  rp_z;
  logic                  rp_ovrf, rp_udrf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign s_in    = fp_X[EXP_W+MAN_W] ^ fp_Y[EXP_W+MAN_W];
  assign x_zero  = is_zero(fp_X) || is_sub(fp_X);
  assign y_zero  = is_zero(fp_Y) || is_sub(fp_Y);
  assign x_inf   = is_inf(fp_X);
  assign y_inf   = is_inf(fp_Y);
  assign any_nan = is_nan(fp_X) || is_nan(fp_Y);

  // rem < 2*my always holds, so the shifted remainder never loses its top bit.
  assign diff   = {1'b0, rem} - {2'b00, my};
  assign q_bit  = ~diff[SW+1];
  assign rem_nx = (q_bit ? diff[SW:0] : rem) << 1;

  fp_round_pack #(
    .MAN_W (MAN_W),
    .EXP_W (EXP_W),
    .QBITS (QBITS)
  ) u_round_pack (
    .sign   (sign),
    .e_z    (e_z),
    .quo    (quo),
    .sticky (rem != '0),
    .r_mode (rm),
    .fp_z   (rp_z),
    .ovrf   (rp_ovrf),
    .udrf   (rp_udrf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      my    <= '0;
      rem   <= '0;
      quo   <= '0;
      idx   <= '0;
      e_z   <= '0;
      sign  <= 1'b0;
      rm    <= '0;
      fp_Z  <= '0;
      ovrf  <= 1'b0;
      udrf  <= 1'b0;
      divz  <= 1'b0;
      nv    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= s_in;
          rm   <= r_mode;
          {ovrf, udrf, divz, nv} <= '0;
          if (any_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            fp_Z  <= FP_QNAN;
            nv    <= 1'b1;
            state <= DONE;
          end else if (x_inf) begin
            fp_Z  <= {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            state <= DONE;
          end else if (y_zero) begin
            fp_Z  <= {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            divz  <= 1'b1;
            state <= DONE;
          end else if (x_zero || y_inf) begin
            fp_Z  <= {s_in, {(EXP_W+MAN_W){1'b0}}};
            state <= DONE;
          end else begin
            my    <= {1'b1, fp_Y[MAN_W-1:0]};
            rem   <= {2'b01, fp_X[MAN_W-1:0]};
            quo   <= '0;
            idx   <= CW'(QBITS - 1);
            e_z   <= EW2'(fp_X[EXP_W+MAN_W-1:MAN_W]) - EW2'(fp_Y[EXP_W+MAN_W-1:MAN_W]) + BIAS_E;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          quo[idx] <= q_bit;
          rem      <= rem_nx;
          idx      <= idx - 1'b1;
          if (idx == '0)
            state <= ROUND;
`ifdef FP_DIV_EARLY_TERM_EN
          else if (rem_nx == '0)
            state <= ROUND;
`endif
        end
        ROUND: begin
          fp_Z  <= rp_z;
          ovrf  <= rp_ovrf;
          udrf  <= rp_udrf;
          divz  <= 1'b0;
          nv    <= 1'b0;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
